// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and types for the LCD host driver.
// Command codes, image/window geometry, driver FSM states.
package lcd_pkg;

  localparam int IMG_W   = 12;
  localparam int IMG_H   = 9;
  localparam int IMG_PIX = IMG_W * IMG_H;
  localparam int OUT_PIX = 16;
  localparam int TIMEOUT = 255;

  localparam logic [2:0] CMD_LOAD     = 3'd0;
  localparam logic [2:0] CMD_ZOOM_IN  = 3'd1;
  localparam logic [2:0] CMD_ZOOM_FIT = 3'd2;
  localparam logic [2:0] CMD_RIGHT    = 3'd3;
  localparam logic [2:0] CMD_LEFT     = 3'd4;
  localparam logic [2:0] CMD_UP       = 3'd5;
  localparam logic [2:0] CMD_DOWN     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_LOAD,
    S_WAIT_OUT,
    S_CAPTURE,
    S_DONE
  } drv_state_e;

endpackage

// File: rtl/lcd_host_driver_if.sv
// lcd_host_driver_if: host <-> LCD controller bus.
// master (host): drives cmd/cmd_valid/datain; samples busy/dataout/output_valid.
interface lcd_host_driver_if;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] datain;
  logic       busy;
  logic [7:0] dataout;
  logic       output_valid;

  modport master (
    output cmd, cmd_valid, datain,
    input  busy, dataout, output_valid
  );

  modport slave (
    input  cmd, cmd_valid, datain,
    output busy, dataout, output_valid
  );
endinterface

// File: rtl/lcd_capture_buf.sv
// lcd_capture_buf: 16x8 capture register file, one write port, comb read.
// Ports: clk, rst_n, we/widx/wdata (write), ridx/rdata (read).
module lcd_capture_buf
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [3:0] widx,
  input  logic [7:0] wdata,
  input  logic [3:0] ridx,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [OUT_PIX];
  logic [7:0] mem_d [OUT_PIX];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[widx] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_PIX; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/lcd_host_driver.sv
// lcd_host_driver: issues commands to the LCD controller, streams the
// image on load, captures the 16-pixel result window.
// Ports: clk, reset (async, low), req_*/img_* upstream, ctl bus,
// rd_idx/rd_pix buffer read, done pulse, sticky err.
module lcd_host_driver
  import lcd_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [2:0]             req_cmd,
  output logic                   req_ready,
  output logic [6:0]             img_addr,
  input  logic [7:0]             img_data,
  lcd_host_driver_if.master      ctl,
  input  logic [3:0]             rd_idx,
  output logic [7:0]             rd_pix,
  output logic                   done,
  output logic                   err
);

  localparam logic [6:0] P_LAST   = 7'(IMG_PIX - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [4:0] CNT_LAST = 5'(OUT_PIX - 1);

  drv_state_e state_q, state_d;
  logic [2:0] cmd_q, cmd_d;
  logic [7:0] datain_q, datain_d;
  logic [6:0] p_q, p_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] to_q, to_d;
  logic       err_q, err_d;
  logic       cmd_valid;
  logic       we;
  logic [3:0] widx;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    datain_d  = 8'd0;
    p_d       = p_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    err_d     = err_q;
    we        = 1'b0;
    widx      = 4'd0;
    img_addr  = 7'd0;
    req_ready = 1'b0;
    cmd_valid = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = !ctl.busy;
        if (req_valid && !ctl.busy) begin
          cmd_d   = req_cmd;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_q == CMD_LOAD) begin
          // ROM[0] is addressed this cycle, lands on datain next
          datain_d = img_data;
          state_d  = S_LOAD;
        end else begin
          state_d = S_WAIT_OUT;
        end
      end
      S_LOAD: begin
        img_addr = p_q + 7'd1;
        if (p_q == P_LAST) begin
          p_d     = 7'd0;
          state_d = S_WAIT_OUT;
        end else begin
          p_d      = p_q + 7'd1;
          datain_d = img_data;
        end
      end
      S_WAIT_OUT: begin
        if (ctl.output_valid) begin
          we      = 1'b1;
          cnt_d   = 5'd1;
          to_d    = 8'd0;
          state_d = S_CAPTURE;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          to_d    = 8'd0;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      S_CAPTURE: begin
        if (ctl.output_valid) begin
          we    = 1'b1;
          widx  = cnt_q[3:0];
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = 5'd0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cmd_q    <= 3'd0;
      datain_q <= 8'd0;
      p_q      <= 7'd0;
      cnt_q    <= 5'd0;
      to_q     <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      datain_q <= datain_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      err_q    <= err_d;
    end
  end

  assign ctl.cmd       = cmd_q;
  assign ctl.cmd_valid = cmd_valid;
  assign ctl.datain    = datain_q;
  assign err           = err_q;

  lcd_capture_buf u_buf (
    .clk   (clk),
    .rst_n (reset),
    .we    (we),
    .widx  (widx),
    .wdata (ctl.dataout),
    .ridx  (rd_idx),
    .rdata (rd_pix)
  );

endmodule

// File: tb/tb_lcd_host_driver.sv
// tb_lcd_host_driver: directed bench for lcd_host_driver.
// Plays image ROM and LCD controller; checks against hand values.
module tb_lcd_host_driver;
  import lcd_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_cmd = 3'd0;
  logic       req_ready;
  logic [6:0] img_addr;
  logic [7:0] img_data;
  logic [3:0] rd_idx = 4'd0;
  logic [7:0] rd_pix;
  logic       done;
  logic       err;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int cv_cnt = 0;
  int d0, c0;

  logic [7:0] rom [128];
  logic [7:0] exp_buf [16];

  lcd_host_driver_if bus();

  always #5 clk = ~clk;

  assign img_data = rom[img_addr];

  always @(posedge clk) begin
    if (done) done_cnt++;
    if (bus.cmd_valid) cv_cnt++;
  end

  lcd_host_driver dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_ready (req_ready),
    .img_addr  (img_addr),
    .img_data  (img_data),
    .ctl       (bus),
    .rd_idx    (rd_idx),
    .rd_pix    (rd_pix),
    .done      (done),
    .err       (err)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic request(logic [2:0] c);
    req_valid = 1'b1;
    req_cmd = c;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic stream(int n, int base);
    for (int j = 0; j < n; j++) begin
      bus.output_valid = 1'b1;
      bus.dataout = 8'(base + j);
      tick();
    end
    bus.output_valid = 1'b0;
    bus.dataout = 8'd0;
  endtask

  task automatic check_buf(string tag);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      check($sformatf("%s_%0d", tag, i), rd_pix, exp_buf[i]);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = (i < 108) ? 8'(i) : 8'd0;
    bus.busy = 1'b0;
    bus.output_valid = 1'b0;
    bus.dataout = 8'd0;

    // reset values
    #12;
    check("rst_ready", req_ready, 1);
    check("rst_cv", bus.cmd_valid, 0);
    check("rst_cmd", bus.cmd, 0);
    check("rst_datain", bus.datain, 0);
    check("rst_addr", img_addr, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    for (int i = 0; i < 16; i++) exp_buf[i] = 8'd0;
    check_buf("rst_buf");
    reset = 1'b1;
    tick();

    // load
    d0 = done_cnt;
    c0 = cv_cnt;
    request(CMD_LOAD);
    check("load_cv", bus.cmd_valid, 1);
    check("load_cmd", bus.cmd, CMD_LOAD);
    check("load_addr0", img_addr, 0);
    for (int k = 1; k <= 108; k++) begin
      tick();
      check($sformatf("load_d%0d", k), bus.datain, k - 1);
    end
    tick();
    check("load_end", bus.datain, 0);
    repeat (3) tick();
    stream(16, 200);
    check("load_done", done, 1);
    tick();
    check("load_done_off", done, 0);
    check("load_ready", req_ready, 1);
    check("load_ndone", done_cnt - d0, 1);
    check("load_ncv", cv_cnt - c0, 1);
    for (int i = 0; i < 16; i++) exp_buf[i] = 8'(200 + i);
    check_buf("load_buf");

    // busy gating, then zoom-fit
    tick();
    d0 = done_cnt;
    c0 = cv_cnt;
    bus.busy = 1'b1;
    req_valid = 1'b1;
    req_cmd = CMD_ZOOM_FIT;
    #1;
    check("busy_ready", req_ready, 0);
    tick();
    tick();
    check("busy_cv", bus.cmd_valid, 0);
    bus.busy = 1'b0;
    #1;
    check("busy_rel_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("zf_cv", bus.cmd_valid, 1);
    check("zf_cmd", bus.cmd, CMD_ZOOM_FIT);
    tick();
    check("zf_cv_off", bus.cmd_valid, 0);
    check("zf_datain", bus.datain, 0);
    check("zf_addr", img_addr, 0);
    for (int j = 0; j < 16; j++) begin
      exp_buf[j] = 8'(13 + 24 * (j / 4) + 3 * (j % 4));
      bus.output_valid = 1'b1;
      bus.dataout = exp_buf[j];
      tick();
    end
    bus.output_valid = 1'b0;
    check("zf_done", done, 1);
    tick();
    check("zf_ndone", done_cnt - d0, 1);
    check("zf_ncv", cv_cnt - c0, 1);
    check_buf("zf_buf");

    // gapped output_valid with a trailing extra byte
    tick();
    d0 = done_cnt;
    request(CMD_RIGHT);
    tick();
    stream(8, 100);
    repeat (3) tick();
    stream(8, 108);
    check("gap_done", done, 1);
    bus.output_valid = 1'b1;
    bus.dataout = 8'hEE;
    tick();
    bus.output_valid = 1'b0;
    check("gap_done_off", done, 0);
    tick();
    check("gap_ndone", done_cnt - d0, 1);
    for (int i = 0; i < 16; i++) exp_buf[i] = 8'(100 + i);
    check_buf("gap_buf");

    // timeout, unsupported code passes through unchanged
    tick();
    d0 = done_cnt;
    request(3'd7);
    check("to_cmd", bus.cmd, 7);
    check("to_cv", bus.cmd_valid, 1);
    tick();
    repeat (254) tick();
    check("to_err_early", err, 0);
    check("to_busy_ready", req_ready, 0);
    tick();
    check("to_err", err, 1);
    check("to_ready", req_ready, 1);
    check("to_ndone", done_cnt - d0, 0);

    // next request clears err; reset lands mid-load at pixel 50
    request(CMD_LOAD);
    check("clr_err", err, 0);
    check("clr_cv", bus.cmd_valid, 1);
    repeat (51) tick();
    check("mid_datain", bus.datain, 50);
    check("mid_addr", img_addr, 51);
    #1;
    reset = 1'b0;
    #1;
    check("mrst_cv", bus.cmd_valid, 0);
    check("mrst_cmd", bus.cmd, 0);
    check("mrst_datain", bus.datain, 0);
    check("mrst_addr", img_addr, 0);
    check("mrst_ready", req_ready, 1);
    check("mrst_err", err, 0);
    check("mrst_done", done, 0);
    for (int i = 0; i < 16; i++) exp_buf[i] = 8'd0;
    check_buf("mrst_buf");
    reset = 1'b1;
    tick();
    check("post_ready", req_ready, 1);
    check("post_cv", bus.cmd_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_host_driver.md
Name: lcd_host_driver

Overview:
- Host-side initiator for the LCD display controller: accepts high-level command requests, drives cmd/cmd_valid into the controller and streams the 12x9 (108-byte) image on datain for load commands.
- Captures the 16-pixel window returned on dataout/output_valid into a local buffer, readable by the upstream sequencer/testbench.
- Sits between the stimulus/image ROM and the controller; it is the mirror of the controller's command/data/result protocol.

Parameters:
- IMG_W, 12, image width in pixels
- IMG_H, 9, image height in pixels
- OUT_PIX, 16, pixels returned per command (4x4 window)
- TIMEOUT, 255, max cycles to wait for the first output_valid before flagging an error

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  upstream command request valid
- req_cmd  in  3  requested command (0 load, 1 zoom-in, 2 zoom-fit, 3 right, 4 left, 5 up, 6 down)
- req_ready  out  1  driver idle and able to accept a request
- img_addr  out  7  image ROM address (0..107)
- img_data  in  8  image ROM data, valid one cycle after img_addr
- cmd  out  3  command to controller
- cmd_valid  out  1  one-cycle command strobe to controller
- datain  out  8  image byte to controller
- busy  in  1  controller busy
- dataout  in  8  controller pixel output
- output_valid  in  1  controller pixel valid
- rd_idx  in  4  capture buffer read index
- rd_pix  out  8  capture buffer pixel at rd_idx (combinational read)
- done  out  1  one-cycle pulse: 16 pixels captured
- err  out  1  sticky timeout flag, cleared by next accepted request

Behaviour:
- Reset (reset=0, async): state IDLE; req_ready=1; cmd=0, cmd_valid=0, datain=0, img_addr=0, done=0, err=0; capture buffer cleared to 0; all counters 0.
- FSM states: IDLE, ISSUE, LOAD, WAIT_OUT, CAPTURE, DONE.
- IDLE: req_ready=1. On req_valid=1 and busy=0: latch req_cmd, clear err, go ISSUE. req_valid while busy=1 is not accepted (req_ready=0 whenever busy=1).
- ISSUE (1 cycle): cmd=latched cmd, cmd_valid=1, img_addr=0. Next state: LOAD if cmd==0, else WAIT_OUT. cmd_valid is never high for more than one cycle per request.
- LOAD: pixel counter p runs 0..107. img_addr=p+1 each cycle; datain registered from img_data, so the datain byte in the k-th cycle after the cmd_valid cycle (k=1..108) is ROM[k-1]. After the 108th byte: datain returns to 0, go WAIT_OUT.
- WAIT_OUT: timeout counter increments each cycle. First cycle with output_valid=1: store dataout at buffer[0], set capture count=1, go CAPTURE. If counter reaches TIMEOUT with no output_valid: set err=1, go IDLE (no done pulse).
- CAPTURE: each cycle output_valid=1 stores dataout at buffer[count], count+1. output_valid low mid-stream: hold (no write, no advance). When count reaches OUT_PIX: go DONE. Extra valid bytes after 16 are ignored.
- DONE: done=1 for exactly one cycle, then IDLE. Buffer contents are held until the next capture overwrites them.
- Widths: p 7 bits (saturates, never wraps past 107); capture count 5 bits; timeout counter 8 bits.
- Unsupported req_cmd (7): accepted and issued unchanged; the response is whatever the controller returns (16 pixels or timeout).
- Reset asserted mid-operation: immediate return to reset values; cmd_valid drops the same instant.

Decomposition:
- Shared package lcd_pkg: command codes (CMD_LOAD=0, CMD_ZOOM_IN=1, CMD_ZOOM_FIT=2, CMD_RIGHT=3, CMD_LEFT=4, CMD_UP=5, CMD_DOWN=6), IMG_W/IMG_H/IMG_PIX=108, OUT_PIX=16, driver FSM state enum.
- One sub-module: lcd_capture_buf (16x8 register file, write-enable/write-index, combinational read).

Test Plan:
- Load: ROM[i]=i, req_cmd=0 -> cmd_valid high 1 cycle with cmd=0; datain = 0,1,...,107 over the next 108 cycles; then 16 captured bytes and a single done pulse.
- Zoom-fit after load: req_cmd=2 -> no datain activity; rd_pix for idx 0..15 equals the controller's 16 output bytes in order, e.g. 13,16,19,22,37,...
- Busy gating: busy=1 while req_valid=1 -> req_ready=0, no cmd_valid; busy falls -> cmd_valid the next cycle.
- Gapped output_valid: 8 valid, 3 idle, 8 valid -> first 16 bytes stored, 17th ignored, done exactly once.
- Timeout: output_valid never asserts -> err=1 after 255 WAIT_OUT cycles, no done, req_ready=1; next accepted request clears err.
- Reset mid-LOAD at pixel 50 -> outputs and buffer return to reset values immediately, state IDLE, req_ready=1.
